pipelined_adder: RTL and testbench

Parametrised, pipelined N-bit ripple-carry adder/subtractor with a valid/ready handshake. The carry chain is broken into SEG-bit segments, one segment per pipeline stage, so wide adds close timing at full clock rate. Throughput is one operation per cycle. It is the successor to the team's fixed 4-bit combinational full adder and feeds datapath blocks that need wide add/sub with backpressure.

---
 rtl/adder_pkg.sv | 17 +
 rtl/seg_adder.sv | 31 +++
 rtl/pipelined_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   num_stages : pipeline depth for a given operand width and segment width
//   seg_lsb    : lowest operand bit handled by a given stage
package adder_pkg;

  // Number of carry-chain segments. This is also the pipeline depth and the latency in cycles.
  // WIDTH must be an integer multiple of SEG.
  function automatic int unsigned num_stages(int unsigned width, int unsigned seg);
    return width / seg;
  endfunction

  // Bit offset of the segment resolved by stage k.
  function automatic int unsigned seg_lsb(int unsigned k, int unsigned seg);
    return k * seg;
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i    : segment operands
//   cin_i       : carry into bit 0
//   s_o         : segment sum
//   cout_o      : carry out of the top bit
//   c_msb_in_o  : carry into the top bit (signed overflow = cout ^ c_msb_in)
module seg_adder #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o,
  output logic           c_msb_in_o
);

  logic [SEG:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o     = c[SEG];
  assign c_msb_in_o = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor with a valid/ready handshake. The carry chain is
// split into SEG-bit segments, and each pipeline stage resolves one segment.
// Ports:
//   clk_i, rst_i             : clock; asynchronous active-high reset
//   in_valid_i / in_ready_o  : operand handshake (in_ready_o is combinational)
//   a_i, b_i, cin_i, sub_i   : operands; sub_i=1 computes a - b - cin
//   out_valid_o / out_ready_i: result handshake
//   s_o, cout_o, ovf_o       : result, raw carry out of the MSB, signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned Stages = num_stages(WIDTH, SEG);
  localparam int unsigned Last   = Stages - 1;

  // One pipeline stage record. sum holds the bits resolved so far. a/b carry the operands
  // forward; only the bits above the resolved segment are consumed downstream.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t st_q [Stages];
  stage_t st_d [Stages];
  logic   seg_ovf [Stages];
  logic   ovf_q, ovf_d;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // A single global stall: every stage shifts together or holds together.
  assign advance    = !st_q[Last].valid || out_ready_i;
  assign in_ready_o = advance;

  // a - b - cin == a + ~b + ~cin
  assign b_eff   = sub_i ? ~b_i : b_i;
  assign cin_eff = cin_i ^ sub_i;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    logic [WIDTH-1:0] op_a, op_b, sum_prev, sum_nx;
    logic             c_prev, v_prev;
    logic [SEG-1:0]   seg_s;
    logic             seg_co, seg_cm;

    if (k == 0) begin : g_first
      assign op_a     = a_i;
      assign op_b     = b_eff;
      assign sum_prev = '0;
      assign c_prev   = cin_eff;
      assign v_prev   = in_valid_i;
    end else begin : g_next
      assign op_a     = st_q[k-1].a;
      assign op_b     = st_q[k-1].b;
      assign sum_prev = st_q[k-1].sum;
      assign c_prev   = st_q[k-1].carry;
      assign v_prev   = st_q[k-1].valid;
    end

    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .a_i        (op_a[seg_lsb(k, SEG) +: SEG]),
      .b_i        (op_b[seg_lsb(k, SEG) +: SEG]),
      .cin_i      (c_prev),
      .s_o        (seg_s),
      .cout_o     (seg_co),
      .c_msb_in_o (seg_cm)
    );

    always_comb begin
      sum_nx = sum_prev;
      sum_nx[seg_lsb(k, SEG) +: SEG] = seg_s;
    end

    assign seg_ovf[k] = seg_co ^ seg_cm;

    assign st_d[k] = '{valid: v_prev, carry: seg_co, sum: sum_nx, a: op_a, b: op_b};
  end

  // Only the MSB segment's overflow is architecturally meaningful.
  assign ovf_d = seg_ovf[Last];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < Stages; k++) begin
        st_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < Stages; k++) begin
        st_q[k] <= st_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid_o = st_q[Last].valid;
  assign s_o         = st_q[Last].sum;
  assign cout_o      = st_q[Last].carry;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, SEG=4): directed vectors with exact
// latency, backpressure, mid-flight reset, and a long random stream against an arithmetic model.
module tb_pipelined_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned SG = 4;
  localparam int unsigned Latency = W / SG;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] s;
  logic         cout, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t exp_q [$];
  vec_t vecs [9];

  pipelined_adder #(
    .WIDTH (W),
    .SEG   (SG)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .s_o         (s),
    .cout_o      (cout),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(logic [W-1:0] ia, logic [W-1:0] ib, logic icin, logic isub);
    longint ua, ub, sa, sb, ci, r, sr;
    res_t o;
    ua = longint'(ia);
    ub = longint'(ib);
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ci = icin ? 64'sd1 : 64'sd0;
    if (!isub) begin
      r      = ua + ub + ci;
      sr     = sa + sb + ci;
      o.cout = (r >= 65536);
    end else begin
      r      = ua - ub - ci;
      sr     = sa - sb - ci;
      o.cout = (r >= 0);
    end
    o.s   = r[W-1:0];
    o.ovf = (sr > 32767) || (sr < -32768);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive on posedge+1, sample on negedge. mode 0: saturating input, out_ready 1,0,0,1.
  // mode 1: random in_valid and out_ready.
  task automatic run_stream(input int n_ops, input int mode);
    int   acc = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    res_t held, e;
    logic held_v;
    held   = '{s: '0, cout: 1'b0, ovf: 1'b0};
    held_v = 1'b0;
    while ((acc < n_ops || exp_q.size() != 0) && cyc < n_ops * 4 + 50) begin
      in_valid  = (acc < n_ops) && ((mode == 0) || ($urandom_range(3) != 0));
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = (mode == 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ($urandom_range(3) != 0);
      @(negedge clk);
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        chk("stall_valid", out_valid, held_v);
        chk("stall_s", s, held.s);
        chk("stall_cout", cout, held.cout);
        chk("stall_ovf", ovf, held.ovf);
      end
      if (out_valid && out_ready) begin
        chk("spurious_result", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_s", s, e.s);
          chk("stream_cout", cout, e.cout);
          chk("stream_ovf", ovf, e.ovf);
        end
      end
      stalled = out_valid && !out_ready;
      held    = '{s: s, cout: cout, ovf: ovf};
      held_v  = out_valid;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stream_accepted", acc, n_ops);
    chk("stream_drained", exp_q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};  // add wrap
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};  // signed overflow
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};  // sub with borrow
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};  // plus borrow-in
    vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};  // carry across segs
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};  // sub overflow
    vecs[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};  // add with cin
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};  // neg + neg
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};  // 0 - 0 - 1

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    #3;
    chk("reset_valid", out_valid, 0);
    chk("reset_s", s, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors with exact latency.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      cin      = vecs[i].cin;
      sub      = vecs[i].sub;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int j = 1; j < int'(Latency); j++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_early_valid", i), out_valid, 0);
        @(posedge clk);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_s", i), s, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      @(posedge clk);
      #1;
    end

    // Backpressure: 8 back-to-back ops, out_ready 1,0,0,1.
    run_stream(8, 0);

    // Reset mid-flight: 3 ops accepted, first reaches the output, then async reset.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 16'h1234 + 16'(i);
      b        = 16'h1111;
      cin      = 1'b0;
      sub      = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_s", s, 16'h2345);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_s", s, 0);
    chk("async_reset_cout", cout, 0);
    chk("async_reset_ovf", ovf, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_stale_result", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Long random stream.
    run_stream(1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
